camino_sched: RTL and testbench
===============================

// Module: camino_sched
// PURPOSE
//  Scheduler/controller for the Main->D0/D1 QoS path. Pops the show-ahead Main FIFO and
//  routes each word to D0 or D1 by its class bit, stalling on destination almost-full.
//  Sequences the path through RESET/INIT/IDLE/ACTIVE/ERROR and drives the latched
//  almost-full thresholds (umbrales) to the three FIFOs. Sits between the FIFOs and the top.
// PARAMETERS
//  BW       6  word width; class bit is data[BW-2] (0->D0, 1->D1), data[BW-1] reserved
//  CNT_W    8  width of per-destination delivered-word counters
// PORTS
//  clk                in   1     single clock, all logic on posedge
//  reset              in   1     synchronous, active-high
//  init               in   1     config request; latches umbrales
//  UmbralesMFs_HIGH   in   4     Main almost-full threshold
//  UmbralesMFs_LOW    in   4     Main almost-empty threshold
//  UmbralesDs_HIGH    in   8     {D1[7:4],D0[3:0]} almost-full thresholds
//  UmbralesDs_LOW     in   8     {D1[7:4],D0[3:0]} almost-empty thresholds
//  Main_empty         in   1     Main FIFO empty
//  Main_data_out      in   BW    Main head word, valid while !Main_empty
//  D0_almost_full     in   1     D0 at/above HIGH threshold
//  D1_almost_full     in   1     D1 at/above HIGH threshold
//  D0_empty, D1_empty in   1     destination FIFO empty flags
//  fifo_err           in   3     overflow/underflow flags {D1,D0,Main}
//  Main_rd            out  1     pop Main (combinational)
//  D0_wr, D1_wr       out  1     push destination (registered)
//  D0_data_in         out  BW    word to D0 (registered)
//  D1_data_in         out  BW    word to D1 (registered)
//  cfg_MF_high/low    out  4     latched Main thresholds
//  cfg_D_high/low     out  8     latched D0/D1 thresholds
//  idle_out           out  1     state==IDLE
//  active_out         out  1     state==ACTIVE
//  error_out          out  1     state==ERROR
//  error_full         out  3     sticky OR of fifo_err since reset
//  D0_count, D1_count out  CNT_W words delivered per destination
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high. While reset=1: state=RESET, every
//   registered output 0 (cfg_*, counters, error_full, D*_wr, D*_data_in); Main_rd=0.
//  FSM (next-state priority top-down):
//   - any state but RESET, fifo_err!=0          -> ERROR
//   - RESET                                      -> INIT (first cycle reset=0)
//   - INIT: cfg_* <= Umbrales* every cycle init=1; init=0 -> IDLE
//   - IDLE: init=1 -> INIT; else !Main_empty -> ACTIVE
//   - ACTIVE: Main_empty & D0_empty & D1_empty & !D0_wr & !D1_wr -> IDLE; init ignored
//   - ERROR: sticky; only reset exits; no pops, no writes
//  Pop: Main_rd = active_out & !Main_empty & fifo_err==0 & !AF(dest),
//   dest=Main_data_out[BW-2], AF(0)=D0_almost_full, AF(1)=D1_almost_full.
//  Strict in-order: head blocked on full dest stalls even if other dest free (HOL blocking).
//  Latency 1: cycle after Main_rd=1, D{dest}_wr=1 and D{dest}_data_in=popped word; the
//   other D*_wr=0. D*_data_in hold last value when not written.
//  Counters: +1 per D*_wr cycle, wrap 2^CNT_W-1 -> 0; never cleared except by reset.
//  error_full <= error_full | fifo_err every non-reset cycle.
//  Reset mid-transfer: pending write dropped, D*_wr=0 next cycle.
//  Entering ERROR with a write pending: that write still completes (already registered).
// STRUCTURE
//  Shared package camino_pkg: state encodings ST_RESET..ST_ERROR (3b), CLASS_BIT=BW-2.
//  Sub-module camino_cfg_regs: umbral latch (load enable, sync clear), instanced once.
//  FSM, pop logic, write pipeline and counters stay in camino_sched.
// TESTING
//  1 reset 3 cycles, init=1 1 cycle, UmbralesDs_HIGH=8'h33 -> cfg_D_high=8'h33, idle_out=1.
//  2 Main holds 6'b01_0001,6'b00_1111 -> D1_wr then D0_wr, each 1 cycle after Main_rd;
//    D1_count=1, D0_count=1; returns to IDLE when all FIFOs empty.
//  3 D1_almost_full=1, head 6'b01_1100, next 6'b00_0101 -> Main_rd=0 (HOL), D0_wr never;
//    drop AF -> both delivered in order.
//  4 fifo_err=3'b010 one cycle during ACTIVE -> ERROR next cycle, error_full=3'b010 held,
//    Main_rd=0 with Main non-empty, until reset.
//  5 256 words to D0 -> D0_count wraps to 0; assert reset with Main_rd=1 -> D0_wr=0 next.
//  6 init=1 in ACTIVE -> ignored, cfg_* unchanged; init=1 in IDLE -> INIT, new cfg latched.

Source files
------------

// File: rtl/camino_pkg.sv
`default_nettype none
// ============================================================================
// Module   : camino_pkg
// Purpose  : Shared definitions for the Main->D0/D1 QoS scheduler: FSM state
//            encoding, default widths and the class-bit locator.
// Contents : state_t (ST_RESET..ST_ERROR, 3 bits), BW_DEFAULT, CNT_W_DEFAULT,
//            CLASS_BIT, class_bit()
// Revision : 1.0 - initial release
// ============================================================================
package camino_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int BW_DEFAULT    = 6;
    localparam int CNT_W_DEFAULT = 8;

    // The top bit of a word is reserved; the bit just below it selects D0/D1.
    function automatic int class_bit(input int bw);
        return bw - 2;
    endfunction

    localparam int CLASS_BIT = class_bit(BW_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/camino_if.sv
`default_nettype none
// ============================================================================
// Module   : camino_if
// Purpose  : FIFO-side bundle of the scheduler: Main FIFO head/pop, the D0/D1
//            push ports and the status flags of all three FIFOs.
// Modports : master - scheduler (drives Main_rd, D*_wr, D*_data_in)
//            slave  - FIFO side (drives flags, Main head word, fifo_err)
// Revision : 1.0 - initial release
// ============================================================================
interface camino_if #(
    parameter int BW = 6
);
    logic          Main_empty;
    logic [BW-1:0] Main_data_out;
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          D0_empty;
    logic          D1_empty;
    logic [2:0]    fifo_err;
    logic          Main_rd;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] D0_data_in;
    logic [BW-1:0] D1_data_in;

    modport master (
        input  Main_empty, Main_data_out, D0_almost_full, D1_almost_full,
        input  D0_empty, D1_empty, fifo_err,
        output Main_rd, D0_wr, D1_wr, D0_data_in, D1_data_in
    );

    modport slave (
        output Main_empty, Main_data_out, D0_almost_full, D1_almost_full,
        output D0_empty, D1_empty, fifo_err,
        input  Main_rd, D0_wr, D1_wr, D0_data_in, D1_data_in
    );
endinterface
`default_nettype wire

// File: rtl/camino_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : camino_cfg_regs
// Purpose  : Holds the FIFO almost-full/almost-empty thresholds (umbrales).
// Ports    : clk, reset (sync, active-high clear), load (latch enable),
//            mf_high_in/mf_low_in [3:0], d_high_in/d_low_in [7:0] -> inputs,
//            mf_high/mf_low [3:0], d_high/d_low [7:0] -> latched outputs
// Revision : 1.0 - initial release
// ============================================================================
module camino_cfg_regs (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       load,
    input  wire logic [3:0] mf_high_in,
    input  wire logic [3:0] mf_low_in,
    input  wire logic [7:0] d_high_in,
    input  wire logic [7:0] d_low_in,
    output logic      [3:0] mf_high,
    output logic      [3:0] mf_low,
    output logic      [7:0] d_high,
    output logic      [7:0] d_low
);
    always_ff @(posedge clk) begin
        if (reset) begin
            mf_high <= 4'd0;
            mf_low  <= 4'd0;
            d_high  <= 8'd0;
            d_low   <= 8'd0;
        end else if (load) begin
            mf_high <= mf_high_in;
            mf_low  <= mf_low_in;
            d_high  <= d_high_in;
            d_low   <= d_low_in;
        end
    end
endmodule
`default_nettype wire

// File: rtl/camino_sched.sv
`default_nettype none
// ============================================================================
// Module   : camino_sched
// Purpose  : Pops the show-ahead Main FIFO and routes each word, strictly in
//            order, to D0 or D1 by its class bit, stalling while the head's
//            destination is almost full. Sequences RESET/INIT/IDLE/ACTIVE/ERROR
//            and drives the latched thresholds to the three FIFOs.
// Ports    : clk, reset (sync, active-high), init, Umbrales* (threshold inputs),
//            bus (camino_if.master: FIFO flags/head in, Main_rd/D*_wr/D*_data_in
//            out), cfg_* (latched thresholds), idle_out/active_out/error_out,
//            error_full (sticky fifo_err), D0_count/D1_count (words delivered)
// Revision : 1.0 - initial release
// ============================================================================
module camino_sched
    import camino_pkg::*;
#(
    parameter int BW    = BW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             init,
    input  wire logic [3:0]       UmbralesMFs_HIGH,
    input  wire logic [3:0]       UmbralesMFs_LOW,
    input  wire logic [7:0]       UmbralesDs_HIGH,
    input  wire logic [7:0]       UmbralesDs_LOW,
    camino_if.master              bus,
    output logic      [3:0]       cfg_MF_high,
    output logic      [3:0]       cfg_MF_low,
    output logic      [7:0]       cfg_D_high,
    output logic      [7:0]       cfg_D_low,
    output logic                  idle_out,
    output logic                  active_out,
    output logic                  error_out,
    output logic      [2:0]       error_full,
    output logic      [CNT_W-1:0] D0_count,
    output logic      [CNT_W-1:0] D1_count
);
    localparam int C_CLASS = class_bit(BW);

    state_t          r_state;
    state_t          w_next;
    logic            w_dest;
    logic            w_dest_af;
    logic            w_no_err;
    logic            w_pop;
    logic            w_drained;
    logic            r_d0_wr;
    logic            r_d1_wr;
    logic [BW-1:0]   r_d0_data;
    logic [BW-1:0]   r_d1_data;

    // Head-of-line word decides which almost-full flag gates the pop; the
    // other destination being free never lets a later word overtake it.
    assign w_dest    = bus.Main_data_out[C_CLASS];
    assign w_dest_af = w_dest ? bus.D1_almost_full : bus.D0_almost_full;
    assign w_no_err  = (bus.fifo_err == 3'b000);
    assign w_pop     = !reset && (r_state == ST_ACTIVE) && !bus.Main_empty
                       && w_no_err && !w_dest_af;

    // A registered write still in flight counts as traffic on the path.
    assign w_drained = bus.Main_empty && bus.D0_empty && bus.D1_empty
                       && !r_d0_wr && !r_d1_wr;

    always_comb begin
        w_next = r_state;
        if ((r_state != ST_RESET) && !w_no_err) begin
            w_next = ST_ERROR;
        end else begin
            case (r_state)
                ST_RESET:  w_next = ST_INIT;
                ST_INIT:   if (!init) w_next = ST_IDLE;
                ST_IDLE: begin
                    if (init)                 w_next = ST_INIT;
                    else if (!bus.Main_empty) w_next = ST_ACTIVE;
                end
                ST_ACTIVE: if (w_drained) w_next = ST_IDLE;
                ST_ERROR:  w_next = ST_ERROR;
                default:   w_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RESET;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            r_state    <= w_next;
            idle_out   <= (w_next == ST_IDLE);
            active_out <= (w_next == ST_ACTIVE);
            error_out  <= (w_next == ST_ERROR);
        end
    end

    // Write pipeline, delivered-word counters and sticky error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0_wr    <= 1'b0;
            r_d1_wr    <= 1'b0;
            r_d0_data  <= '0;
            r_d1_data  <= '0;
            D0_count   <= '0;
            D1_count   <= '0;
            error_full <= 3'b000;
        end else begin
            r_d0_wr <= w_pop && !w_dest;
            r_d1_wr <= w_pop && w_dest;
            if (w_pop && !w_dest) r_d0_data <= bus.Main_data_out;
            if (w_pop && w_dest)  r_d1_data <= bus.Main_data_out;
            if (r_d0_wr) D0_count <= D0_count + CNT_W'(1);
            if (r_d1_wr) D1_count <= D1_count + CNT_W'(1);
            error_full <= error_full | bus.fifo_err;
        end
    end

    assign bus.Main_rd    = w_pop;
    assign bus.D0_wr      = r_d0_wr;
    assign bus.D1_wr      = r_d1_wr;
    assign bus.D0_data_in = r_d0_data;
    assign bus.D1_data_in = r_d1_data;

    camino_cfg_regs u_cfg_regs (
        .clk        (clk),
        .reset      (reset),
        .load       ((r_state == ST_INIT) && init),
        .mf_high_in (UmbralesMFs_HIGH),
        .mf_low_in  (UmbralesMFs_LOW),
        .d_high_in  (UmbralesDs_HIGH),
        .d_low_in   (UmbralesDs_LOW),
        .mf_high    (cfg_MF_high),
        .mf_low     (cfg_MF_low),
        .d_high     (cfg_D_high),
        .d_low      (cfg_D_low)
    );
endmodule
`default_nettype wire

// File: tb/tb_camino_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_camino_sched
// Purpose  : Self-checking bench for camino_sched. A queue stands in for the
//            Main FIFO, a second queue holds the push order the destinations
//            must observe, and a mode/threshold/counter model derived from the
//            path's rules predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camino_sched;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    typedef struct {
        logic [5:0] word;
        logic       to_d1;
    } route_vec_t;

    typedef struct {
        logic [3:0] mf_h;
        logic [3:0] mf_l;
        logic [7:0] d_h;
        logic [7:0] d_l;
    } cfg_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic [3:0] umf_h, umf_l;
    logic [7:0] ud_h, ud_l;
    logic       af0, af1, d0e, d1e;
    logic [2:0] ferr;

    logic [3:0] cfg_MF_high, cfg_MF_low;
    logic [7:0] cfg_D_high, cfg_D_low;
    logic       idle_out, active_out, error_out;
    logic [2:0] error_full;
    logic [7:0] D0_count, D1_count;

    logic [5:0] main_q[$];
    logic [5:0] sb_q[$];

    int         m_mode;
    logic [3:0] m_mfh, m_mfl;
    logic [7:0] m_dh, m_dl;
    logic [2:0] m_ef;
    logic [7:0] m_c0, m_c1;
    logic       m_w0, m_w1;
    logic [5:0] m_d0, m_d1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    camino_if #(.BW(6)) bus ();

    camino_sched #(.BW(6), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (rst),
        .init             (init),
        .UmbralesMFs_HIGH (umf_h),
        .UmbralesMFs_LOW  (umf_l),
        .UmbralesDs_HIGH  (ud_h),
        .UmbralesDs_LOW   (ud_l),
        .bus              (bus.master),
        .cfg_MF_high      (cfg_MF_high),
        .cfg_MF_low       (cfg_MF_low),
        .cfg_D_high       (cfg_D_high),
        .cfg_D_low        (cfg_D_low),
        .idle_out         (idle_out),
        .active_out       (active_out),
        .error_out        (error_out),
        .error_full       (error_full),
        .D0_count         (D0_count),
        .D1_count         (D1_count)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    task automatic refresh();
        bus.Main_empty     = (main_q.size() == 0);
        bus.Main_data_out  = (main_q.size() != 0) ? main_q[0] : 6'd0;
        bus.D0_almost_full = af0;
        bus.D1_almost_full = af1;
        bus.D0_empty       = d0e;
        bus.D1_empty       = d1e;
        bus.fifo_err       = ferr;
    endtask

    task automatic push(input logic [5:0] w);
        main_q.push_back(w);
        sb_q.push_back(w);
    endtask

    // One clock: predict from the rules, let the edge happen, compare.
    task automatic cycle();
        logic [5:0] hd, w;
        logic       dst, exp_rd, rd_s, nw0, nw1, drained;
        refresh();
        @(negedge clk);
        hd     = (main_q.size() != 0) ? main_q[0] : 6'd0;
        dst    = hd[4];
        exp_rd = !rst && (m_mode == M_ACTIVE) && (main_q.size() != 0)
                 && (ferr == 3'b000) && !(dst ? af1 : af0);
        chk("main_rd", 32'(bus.Main_rd), 32'(exp_rd));
        rd_s = bus.Main_rd;
        nw0  = exp_rd && !dst;
        nw1  = exp_rd && dst;
        if (rst) begin
            m_mode = M_RESET;
            m_mfh = 0; m_mfl = 0; m_dh = 0; m_dl = 0;
            m_ef = 0; m_c0 = 0; m_c1 = 0; m_d0 = 0; m_d1 = 0;
            nw0 = 0; nw1 = 0;
        end else begin
            m_c0 = m_c0 + 8'(m_w0);
            m_c1 = m_c1 + 8'(m_w1);
            if (nw0) m_d0 = hd;
            if (nw1) m_d1 = hd;
            m_ef = m_ef | ferr;
            drained = (main_q.size() == 0) && d0e && d1e && !m_w0 && !m_w1;
            if (m_mode != M_RESET && ferr != 3'b000) m_mode = M_ERROR;
            else if (m_mode == M_RESET) m_mode = M_INIT;
            else if (m_mode == M_INIT) begin
                if (init) begin m_mfh = umf_h; m_mfl = umf_l; m_dh = ud_h; m_dl = ud_l; end
                else m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (init) m_mode = M_INIT;
                else if (main_q.size() != 0) m_mode = M_ACTIVE;
            end else if (m_mode == M_ACTIVE) begin
                if (drained) m_mode = M_IDLE;
            end
        end
        m_w0 = nw0;
        m_w1 = nw1;
        @(posedge clk);
        #1;
        if (rd_s && main_q.size() != 0) w = main_q.pop_front();
        refresh();
        chk("idle_out",   32'(idle_out),   32'(m_mode == M_IDLE));
        chk("active_out", 32'(active_out), 32'(m_mode == M_ACTIVE));
        chk("error_out",  32'(error_out),  32'(m_mode == M_ERROR));
        chk("cfg_mf_hi",  32'(cfg_MF_high), 32'(m_mfh));
        chk("cfg_mf_lo",  32'(cfg_MF_low),  32'(m_mfl));
        chk("cfg_d_hi",   32'(cfg_D_high),  32'(m_dh));
        chk("cfg_d_lo",   32'(cfg_D_low),   32'(m_dl));
        chk("error_full", 32'(error_full),  32'(m_ef));
        chk("d0_count",   32'(D0_count),    32'(m_c0));
        chk("d1_count",   32'(D1_count),    32'(m_c1));
        chk("d0_wr",      32'(bus.D0_wr),   32'(m_w0));
        chk("d1_wr",      32'(bus.D1_wr),   32'(m_w1));
        chk("d0_data",    32'(bus.D0_data_in), 32'(m_d0));
        chk("d1_data",    32'(bus.D1_data_in), 32'(m_d1));
        if (bus.D0_wr || bus.D1_wr) begin
            if (sb_q.size() == 0) chk("sb_underrun", 32'(sb_q.size()), 32'd1);
            else begin
                w = sb_q.pop_front();
                chk("sb_order", 32'(bus.D1_wr ? bus.D1_data_in : bus.D0_data_in), 32'(w));
                chk("sb_class", 32'(bus.D1_wr), 32'(w[4]));
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        main_q.delete();
        sb_q.delete();
        rst = 1'b0;
        init = 1'b0;
        run(2);
    endtask

    task automatic run_route(input route_vec_t v);
        logic found = 1'b0;
        push(v.word);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!found && (bus.D0_wr || bus.D1_wr)) begin
                found = 1'b1;
                chk("route_dest", 32'(bus.D1_wr), 32'(v.to_d1));
                chk("route_data", 32'(v.to_d1 ? bus.D1_data_in : bus.D0_data_in), 32'(v.word));
            end
        end
        chk("route_seen", 32'(found), 32'd1);
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((main_q.size() != 0 || sb_q.size() != 0) && i < budget) begin
            cycle();
            i++;
        end
        chk("drain_budget", 32'(sb_q.size()), 32'd0);
        run(3);
    endtask

    route_vec_t route_tbl[6];
    cfg_vec_t   cfg_tbl[3];

    initial begin
        logic seen;
        route_tbl[0] = '{6'b00_0000, 1'b0};
        route_tbl[1] = '{6'b01_0000, 1'b1};
        route_tbl[2] = '{6'b10_1010, 1'b0};
        route_tbl[3] = '{6'b11_0101, 1'b1};
        route_tbl[4] = '{6'b00_1111, 1'b0};
        route_tbl[5] = '{6'b11_1111, 1'b1};
        cfg_tbl[0] = '{4'h5, 4'h1, 8'h77, 8'h22};
        cfg_tbl[1] = '{4'hF, 4'h0, 8'hA9, 8'h10};
        cfg_tbl[2] = '{4'h0, 4'hE, 8'h00, 8'hFF};

        rst = 1; init = 0; umf_h = 0; umf_l = 0; ud_h = 0; ud_l = 0;
        af0 = 0; af1 = 0; d0e = 1; d1e = 1; ferr = 0;
        m_mode = M_RESET; m_mfh = 0; m_mfl = 0; m_dh = 0; m_dl = 0;
        m_ef = 0; m_c0 = 0; m_c1 = 0; m_w0 = 0; m_w1 = 0; m_d0 = 0; m_d1 = 0;

        // 1: reset, configure, land in IDLE
        run(3);
        rst = 0;
        cycle();
        init = 1; umf_h = 4'hA; umf_l = 4'h2; ud_h = 8'h33; ud_l = 8'h11;
        cycle();
        init = 0;
        cycle();
        chk("t1_cfg_d_high", 32'(cfg_D_high), 32'h33);
        chk("t1_idle", 32'(idle_out), 32'd1);

        // 2: one word per class, then back to IDLE
        push(6'b01_0001);
        push(6'b00_1111);
        run(6);
        chk("t2_d1_count", 32'(D1_count), 32'd1);
        chk("t2_d0_count", 32'(D0_count), 32'd1);
        chk("t2_idle", 32'(idle_out), 32'd1);
        foreach (route_tbl[i]) run_route(route_tbl[i]);

        // 3: head-of-line blocking on D1 almost full
        af1 = 1;
        push(6'b01_1100);
        push(6'b00_0101);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.D0_wr) seen = 1'b1;
        end
        chk("t3_hol_no_d0", 32'(seen), 32'd0);
        chk("t3_hol_rd", 32'(bus.Main_rd), 32'd0);
        af1 = 0;
        drain(20);
        chk("t3_d1_count", 32'(D1_count), 32'd5);
        chk("t3_d0_count", 32'(D0_count), 32'd5);

        // 4: fifo error during ACTIVE is sticky until reset
        af0 = 1; af1 = 1;
        push(6'b00_0011);
        run(2);
        ferr = 3'b010;
        cycle();
        ferr = 3'b000;
        af0 = 0; af1 = 0;
        run(4);
        chk("t4_error", 32'(error_out), 32'd1);
        chk("t4_error_full", 32'(error_full), 32'h2);
        chk("t4_no_pop", 32'(bus.Main_rd), 32'd0);
        do_reset();
        chk("t4_idle_after_reset", 32'(idle_out), 32'd1);

        // 5: 256 words to D0 wrap its counter; reset during a pop
        for (int i = 0; i < 256; i++) push({1'($urandom_range(1)), 1'b0, 4'($urandom_range(15))});
        drain(400);
        chk("t5_d0_wrap", 32'(D0_count), 32'd0);
        push(6'b00_0001); push(6'b00_0010); push(6'b00_0011);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            #1;
            if (bus.Main_rd) seen = 1'b1;
        end
        chk("t5_rd_before_reset", 32'(seen), 32'd1);
        rst = 1;
        #1;
        chk("t5_rst_gates_rd", 32'(bus.Main_rd), 32'd0);
        cycle();
        chk("t5_rst_drop_d0", 32'(bus.D0_wr), 32'd0);
        main_q.delete();
        sb_q.delete();
        rst = 0;
        run(2);

        // 6: init ignored in ACTIVE, honoured in IDLE
        af0 = 1;
        push(6'b00_1001);
        run(2);
        init = 1; umf_h = 4'hC; ud_h = 8'hC3;
        run(2);
        chk("t6_active_hold", 32'(active_out), 32'd1);
        chk("t6_cfg_kept", 32'(cfg_D_high), 32'h0);
        init = 0; af0 = 0;
        drain(20);
        foreach (cfg_tbl[i]) begin
            umf_h = cfg_tbl[i].mf_h; umf_l = cfg_tbl[i].mf_l;
            ud_h  = cfg_tbl[i].d_h;  ud_l  = cfg_tbl[i].d_l;
            init = 1;
            run(2);
            init = 0;
            cycle();
            chk("tbl_mf_high", 32'(cfg_MF_high), 32'(cfg_tbl[i].mf_h));
            chk("tbl_mf_low",  32'(cfg_MF_low),  32'(cfg_tbl[i].mf_l));
            chk("tbl_d_high",  32'(cfg_D_high),  32'(cfg_tbl[i].d_h));
            chk("tbl_d_low",   32'(cfg_D_low),   32'(cfg_tbl[i].d_l));
            chk("tbl_idle",    32'(idle_out),    32'd1);
        end

        // Randomized traffic with back-pressure and occasional reconfiguration
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 45) push(6'($urandom));
            if ($urandom_range(99) < 20) af0 = ~af0;
            if ($urandom_range(99) < 20) af1 = ~af1;
            d0e = ($urandom_range(99) < 70);
            d1e = ($urandom_range(99) < 70);
            init = ($urandom_range(99) < 3);
            if (init) begin
                umf_h = 4'($urandom); umf_l = 4'($urandom);
                ud_h = 8'($urandom); ud_l = 8'($urandom);
            end
            cycle();
        end
        init = 0; af0 = 0; af1 = 0; d0e = 1; d1e = 1;
        drain(600);
        chk("rand_idle", 32'(idle_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
